// File: rtl/pulse_stream_checker.sv
// Pulse stream monitor: synchronizes pulse_i, measures high width and preceding low gap,
// checks both against bounds. Optional burst checking under `PULSE_CHECKER_BURST_EN.
module pulse_stream_checker #(
   parameter int g_cnt_width     = 16,
   parameter int g_width_min     = 3,
   parameter int g_width_max     = 3,
   parameter int g_spacing_min   = 27,
   parameter int g_spacing_max   = 57,
   parameter int g_repetition    = 1,
   parameter int g_burst_gap_max = 5
) (
   input  logic                   clk_sys_i,
   input  logic                   rst_sys_i,
   input  logic                   enable_i,
   input  logic                   clr_i,
   input  logic                   pulse_i,
   output logic                   pulse_valid_o,
   output logic [g_cnt_width-1:0] width_o,
   output logic [g_cnt_width-1:0] spacing_o,
   output logic [g_cnt_width-1:0] pulse_count_o,
   output logic                   err_width_o,
   output logic                   err_spacing_o,
   output logic                   err_burst_o
);

   typedef logic [g_cnt_width-1:0] cnt_t;
   typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

   localparam cnt_t CNT_MAX = '1;
   localparam cnt_t CNT_ONE = cnt_t'(1);
   localparam cnt_t WMIN    = cnt_t'(g_width_min);
   localparam cnt_t WMAX    = cnt_t'(g_width_max);
   localparam cnt_t SMIN    = cnt_t'(g_spacing_min);
   localparam cnt_t SMAX    = cnt_t'(g_spacing_max);

   function automatic cnt_t sat_inc(input cnt_t v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   logic   s1_q, s2_q, s3_q;
   logic   rise, fall;
   state_t state_q, state_d;
   cnt_t   wcnt_q, wcnt_d;
   cnt_t   gcnt_q, gcnt_d;
   cnt_t   gap_q, gap_d;
   logic   first_q, first_d;
   logic   valid_q, valid_d;
   cnt_t   width_q, width_d;
   cnt_t   spacing_q, spacing_d;
   cnt_t   count_q, count_d;
   logic   errw_q, errw_d;
   logic   errs_q, errs_d;
`ifdef PULSE_CHECKER_BURST_EN
   localparam cnt_t BGMAX = cnt_t'(g_burst_gap_max);
   localparam cnt_t REP   = cnt_t'(g_repetition);
   cnt_t   blen_q, blen_d;
   logic   intra_q, intra_d;
   logic   errb_q, errb_d;
`else
   logic   unused_burst_cfg;
   assign unused_burst_cfg = (g_repetition != 0) ^ (g_burst_gap_max != 0);
`endif

   assign rise = s2_q & ~s3_q;
   assign fall = ~s2_q & s3_q;

   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         state_q   <= ST_IDLE;
         wcnt_q    <= '0;
         gcnt_q    <= '0;
         gap_q     <= '0;
         first_q   <= 1'b1;
         valid_q   <= 1'b0;
         width_q   <= '0;
         spacing_q <= '0;
         count_q   <= '0;
         errw_q    <= 1'b0;
         errs_q    <= 1'b0;
`ifdef PULSE_CHECKER_BURST_EN
         blen_q    <= '0;
         intra_q   <= 1'b0;
         errb_q    <= 1'b0;
`endif
      end else begin
         s1_q      <= pulse_i;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         gcnt_q    <= gcnt_d;
         gap_q     <= gap_d;
         first_q   <= first_d;
         valid_q   <= valid_d;
         width_q   <= width_d;
         spacing_q <= spacing_d;
         count_q   <= count_d;
         errw_q    <= errw_d;
         errs_q    <= errs_d;
`ifdef PULSE_CHECKER_BURST_EN
         blen_q    <= blen_d;
         intra_q   <= intra_d;
         errb_q    <= errb_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      gcnt_d    = gcnt_q;
      gap_d     = gap_q;
      first_d   = first_q;
      valid_d   = 1'b0;
      width_d   = width_q;
      spacing_d = spacing_q;
      // Clear first, so an error or count event in the same cycle still lands
      count_d   = clr_i ? '0 : count_q;
      errw_d    = clr_i ? 1'b0 : errw_q;
      errs_d    = clr_i ? 1'b0 : errs_q;
`ifdef PULSE_CHECKER_BURST_EN
      blen_d    = blen_q;
      intra_d   = intra_q;
      errb_d    = clr_i ? 1'b0 : errb_q;
`endif
      if (!enable_i) begin
         state_d = ST_IDLE;
         first_d = 1'b1;
`ifdef PULSE_CHECKER_BURST_EN
         blen_d  = '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rise) begin
                  state_d = ST_HIGH;
                  wcnt_d  = CNT_ONE;
                  gap_d   = '0;
                  first_d = 1'b1;
`ifdef PULSE_CHECKER_BURST_EN
                  intra_d = 1'b0;
`endif
               end
            end
            ST_HIGH: begin
               if (fall) begin
                  state_d   = ST_LOW;
                  valid_d   = 1'b1;
                  width_d   = wcnt_q;
                  spacing_d = gap_q;
                  count_d   = sat_inc(count_d);
                  gcnt_d    = CNT_ONE;
                  if (wcnt_q < WMIN || wcnt_q > WMAX) errw_d = 1'b1;
`ifdef PULSE_CHECKER_BURST_EN
                  blen_d = sat_inc(blen_q);
                  if (!first_q && !intra_q && gap_q < SMIN) errs_d = 1'b1;
`else
                  if (!first_q && gap_q < SMIN) errs_d = 1'b1;
`endif
               end else begin
                  wcnt_d = sat_inc(wcnt_q);
               end
            end
            ST_LOW: begin
               if (rise) begin
                  state_d = ST_HIGH;
                  gap_d   = gcnt_q;
                  wcnt_d  = CNT_ONE;
                  first_d = 1'b0;
`ifdef PULSE_CHECKER_BURST_EN
                  intra_d = (gcnt_q <= BGMAX);
`endif
               end else if (!s2_q) begin
                  gcnt_d = sat_inc(gcnt_q);
                  // Gap timeout flagged as soon as the counter passes the maximum
                  if (gcnt_q == SMAX) errs_d = 1'b1;
`ifdef PULSE_CHECKER_BURST_EN
                  if (gcnt_q == BGMAX) begin
                     if (blen_q != REP) errb_d = 1'b1;
                     blen_d = '0;
                  end
`endif
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign pulse_valid_o = valid_q;
   assign width_o       = width_q;
   assign spacing_o     = spacing_q;
   assign pulse_count_o = count_q;
   assign err_width_o   = errw_q;
   assign err_spacing_o = errs_q;
`ifdef PULSE_CHECKER_BURST_EN
   assign err_burst_o   = errb_q;
`else
   assign err_burst_o   = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_stream_checker.sv
// Scoreboard bench for pulse_stream_checker: directed pulse trains, expected results queued
// at stimulus time and popped by a monitor on each pulse_valid_o strobe.
module tb_pulse_stream_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        clr = 1'b0;
   logic        pulse = 1'b0;
   logic        valid;
   logic [15:0] width, spacing, count;
   logic        errw, errs, errb;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int w;
      int sp;
      int cnt;
      int ew;
      int es;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

`ifdef PULSE_CHECKER_BURST_EN
   pulse_stream_checker #(.g_repetition(3)) dut (
`else
   pulse_stream_checker dut (
`endif
      .clk_sys_i(clk), .rst_sys_i(rst), .enable_i(enable), .clr_i(clr), .pulse_i(pulse),
      .pulse_valid_o(valid), .width_o(width), .spacing_o(spacing), .pulse_count_o(count),
      .err_width_o(errw), .err_spacing_o(errs), .err_burst_o(errb));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int w, input int sp, input int cnt, input int ew, input int es);
      exp_t e;
      e.w = w; e.sp = sp; e.cnt = cnt; e.ew = ew; e.es = es;
      sb.push_back(e);
   endtask

   task automatic pulse_tx(input int h, input int l, input int sp, input int cnt,
                           input int ew, input int es);
      push(h, sp, cnt, ew, es);
      pulse = 1'b1;
      repeat (h) @(negedge clk);
      pulse = 1'b0;
      repeat (l) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst && valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got strobe expected none (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("width", int'(width), e.w);
            chk("spacing", int'(spacing), e.sp);
            chk("count", int'(count), e.cnt);
            chk("err_width", int'(errw), e.ew);
            chk("err_spacing", int'(errs), e.es);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", int'(valid), 0);
      chk("rst_width", int'(width), 0);
      chk("rst_spacing", int'(spacing), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_errw", int'(errw), 0);
      chk("rst_errs", int'(errs), 0);
      chk("rst_errb", int'(errb), 0);
      enable = 1'b1;
      repeat (5) @(negedge clk);

`ifdef PULSE_CHECKER_BURST_EN
      for (int b = 0; b < 2; b++)
         for (int p = 0; p < 3; p++)
            pulse_tx(3, (p == 2) ? 40 : 3,
                     (b == 0 && p == 0) ? 0 : ((p == 0) ? 40 : 3), b * 3 + p + 1, 0, 0);
      chk("burst_ok_errb", int'(errb), 0);
      pulse_tx(3, 3, 40, 7, 0, 0);
      push(3, 3, 8, 0, 0);
      pulse = 1'b1;
      repeat (3) @(negedge clk);
      pulse = 1'b0;
      repeat (7) @(negedge clk);
      chk("burst_short_pre", int'(errb), 0);
      @(negedge clk);
      chk("burst_short_errb", int'(errb), 1);
      chk("burst_short_errs", int'(errs), 0);
      repeat (20) @(negedge clk);
`else
      // Nominal train: 3 high / 27 low
      for (int k = 0; k < 10; k++)
         pulse_tx(3, 27, (k == 0) ? 0 : 27, k + 1, 0, 0);
      chk("train_count", int'(count), 10);

      // Wide pulse, sticky width error, then clear during the gap
      pulse_tx(5, 10, 27, 11, 1, 0);
      chk("wide_sticky", int'(errw), 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_count", int'(count), 0);
      chk("clr_errw", int'(errw), 0);
      repeat (16) @(negedge clk);

      // Short gap caught at the following pulse
      pulse_tx(3, 20, 27, 1, 0, 0);
      pulse_tx(3, 27, 20, 2, 0, 1);

      // Clear mid-pulse, then hold low past the gap maximum
      push(3, 27, 1, 0, 0);
      pulse = 1'b1;
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      pulse = 1'b0;
      repeat (59) @(negedge clk);
      chk("timeout_pre", int'(errs), 0);
      @(negedge clk);
      chk("timeout_errs", int'(errs), 1);
      repeat (10) @(negedge clk);

      // Disable, clear, then truncated pulse followed by good pulses
      enable = 1'b0;
      repeat (2) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr2_count", int'(count), 0);
      chk("clr2_errs", int'(errs), 0);
      enable = 1'b1;
      repeat (3) @(negedge clk);
      pulse = 1'b1;
      repeat (3) @(negedge clk);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      enable = 1'b1;
      repeat (2) @(negedge clk);
      pulse = 1'b0;
      repeat (20) @(negedge clk);
      chk("trunc_count", int'(count), 0);
      pulse_tx(3, 27, 0, 1, 0, 0);
      pulse_tx(3, 27, 27, 2, 0, 0);
      pulse_tx(3, 27, 27, 3, 0, 0);

      // Clear in the same cycle as a bad-width fall
      push(5, 27, 1, 1, 0);
      pulse = 1'b1;
      repeat (5) @(negedge clk);
      pulse = 1'b0;
      repeat (2) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (24) @(negedge clk);
      chk("coinc_count", int'(count), 1);
      chk("coinc_errw", int'(errw), 1);
      chk("no_burst_err", int'(errb), 0);
`endif
      repeat (5) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
